lifo_drain: RTL and testbench
=============================

Name: lifo_drain

Overview:
- Read-side controller for the team's LIFO stack (push/pop, empty/full, registered dout).
- On a command, pops up to N entries, or until empty, and delivers them in pop order (newest first) on a valid/ready stream with a last marker.
- Sits between the LIFO pop port and downstream consumers, and raises busy so the writer holds off pushes during a drain.

Parameters:
- WIDTH, 8, data width; must match the LIFO WIDTH.
- DEPTH, 8, LIFO depth; sets count range.
- CNT_W, 4, command/count width = clog2(DEPTH+1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  drain request.
- cmd_ready  output  1  high only in IDLE.
- cmd_count  input  CNT_W  words to drain; 0 = drain until empty.
- lifo_pop  output  1  pop strobe to the LIFO; one-cycle pulse.
- lifo_empty  input  1  LIFO empty flag (combinational from index).
- lifo_dout  input  WIDTH  LIFO registered read data; valid the cycle after a pop.
- busy  output  1  high in every state except IDLE; the writer must not push while high.
- m_valid  output  WIDTH-independent 1  output word valid.
- m_ready  input  1  consumer accept.
- m_data  output  WIDTH  output word.
- m_last  output  1  qualifies the final word of this drain.
- done  output  1  one-cycle pulse at drain completion.
- done_count  output  CNT_W  words delivered in the completed drain; held until the next done.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, lifo_pop=0, m_valid=0, m_data=0, m_last=0, done=0, done_count=0, busy=0, cmd_ready=1, and the internal remaining/delivered counters are cleared.
- Reset mid-drain aborts immediately; words already popped and not delivered are discarded.
- States: IDLE, POP, CAPTURE, SEND, FIN.
- IDLE:
  - cmd_valid&&cmd_ready loads remaining=cmd_count, sets mode_all=(cmd_count==0), clears delivered, and goes to POP.
- POP:
  - If lifo_empty=1: no pop, go to FIN. This covers an empty LIFO at command time and count larger than the stack contents.
  - Else drive lifo_pop=1 for exactly this cycle, go to CAPTURE.
- CAPTURE (lifo_dout now valid):
  - Register m_data<=lifo_dout and m_valid<=1.
  - Register m_last<=(!mode_all && remaining==1) || lifo_empty. lifo_empty here reflects the post-pop index.
  - Decrement remaining if !mode_all. Go to SEND.
- SEND:
  - Hold m_valid, m_data and m_last stable until m_ready.
  - On the handshake: delivered+=1, m_valid<=0. If m_last, go to FIN; else go to POP.
- FIN:
  - done=1 for this single cycle and done_count<=delivered. Go to IDLE.
  - The drain-empty case gives done_count=0 with no stream traffic.
- Latency:
  - Command accepted in cycle T: lifo_pop in T+1, m_valid from T+3.
  - After a non-last handshake in cycle S, the next pop is in S+1.
  - Peak throughput is 1 word per 3 cycles.
- At most one pop is outstanding; lifo_pop is never asserted in CAPTURE, SEND, FIN or IDLE.
- cmd_valid while busy is ignored; cmd_ready=0.
- m_last is asserted only together with m_valid.
- delivered never exceeds DEPTH; the arithmetic is CNT_W wide with no wrap for legal use.
- A push in the same cycle as lifo_pop is a protocol violation (the LIFO gives push priority). The writer gates pushes with busy; this block does not detect it.

Decomposition:
- Shared package lifo_pkg holds:
  - WIDTH/DEPTH defaults and the CNT_W function.
  - The drain state enum (IDLE, POP, CAPTURE, SEND, FIN).
- No sub-module: a single FSM plus counters.
- The bench instantiates the existing LIFO alongside lifo_drain.

Test Plan:
- Push 0x11, 0x22, 0x33; cmd_count=0 -> stream 0x33, 0x22, 0x11; m_last on 0x11; done pulse with done_count=3; LIFO empty.
- Push 0x11, 0x22, 0x33; cmd_count=2 -> stream 0x33, 0x22; m_last on 0x22; done_count=2; one entry (0x11) remains, lifo_empty=0.
- Empty LIFO; cmd_count=4 -> no lifo_pop, no m_valid; done in the 2nd cycle after the command; done_count=0.
- Fill to 8 entries (0x01..0x08); cmd_count=0; m_ready low for 5 cycles at word 2 -> m_data=0x07 held stable and no extra pop while stalled; full drain delivers 0x08..0x01, done_count=8.
- 2 entries, cmd_count=5 -> two words; m_last on the second (empty-triggered); done_count=2.
- rst=1 during SEND -> next cycle m_valid=0, busy=0, cmd_ready=1, done=0; a new command then drains normally.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack and its drain controller.
package lifo_pkg;

  localparam int LIFO_WIDTH = 8;
  localparam int LIFO_DEPTH = 8;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    SEND,
    FIN
  } drain_state_t;

endpackage

// File: rtl/lifo.sv
// LIFO stack: push has priority over pop, combinational empty/full, registered read data.
module lifo
  import lifo_pkg::*;
#(
  parameter int WIDTH = LIFO_WIDTH,
  parameter int DEPTH = LIFO_DEPTH,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_idx;
  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] w_top;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_top     = r_idx - CNT_W'(1);
  assign o_empty   = (r_idx == '0);
  assign o_full    = (r_idx == CNT_W'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty && !i_push;
  assign o_dout    = r_dout;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_idx[AW-1:0]] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_dout <= '0;
    end else if (w_do_push) begin
      r_idx <= r_idx + CNT_W'(1);
    end else if (w_do_pop) begin
      r_dout <= r_mem[w_top[AW-1:0]];
      r_idx  <= w_top;
    end
  end

endmodule

// File: rtl/lifo_drain.sv
// Drains up to cmd_count words (or all, when 0) from the LIFO onto a valid/ready
// stream in pop order, one outstanding pop at a time.
module lifo_drain
  import lifo_pkg::*;
#(
  parameter int WIDTH = LIFO_WIDTH,
  parameter int DEPTH = LIFO_DEPTH,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             lifo_pop,
  input  logic             lifo_empty,
  input  logic [WIDTH-1:0] lifo_dout,
  output logic             busy,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             done,
  output logic [CNT_W-1:0] done_count
);

  drain_state_t     r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_delivered;
  logic             r_mode_all;
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_last;
  logic             r_done;
  logic [CNT_W-1:0] r_done_count;

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  // Pop is qualified by the live empty flag so an exhausted stack is never popped.
  assign lifo_pop   = (r_state == POP) && !lifo_empty;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign done       = r_done;
  assign done_count = r_done_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_delivered  <= '0;
      r_mode_all   <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_done       <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_remaining <= cmd_count;
            r_mode_all  <= (cmd_count == '0);
            r_delivered <= '0;
            r_state     <= POP;
          end
        end
        POP: begin
          if (lifo_empty) begin
            r_done       <= 1'b1;
            r_done_count <= r_delivered;
            r_state      <= FIN;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // lifo_empty already reflects the index after the pop just issued.
          r_m_data  <= lifo_dout;
          r_m_valid <= 1'b1;
          r_m_last  <= (!r_mode_all && (r_remaining == CNT_W'(1))) || lifo_empty;
          if (!r_mode_all) r_remaining <= r_remaining - CNT_W'(1);
          r_state   <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            r_delivered <= r_delivered + CNT_W'(1);
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            if (r_m_last) begin
              r_done       <= 1'b1;
              r_done_count <= r_delivered + CNT_W'(1);
              r_state      <= FIN;
            end else begin
              r_state <= POP;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_drain.sv
// Bench for lifo_drain driving a real LIFO, checked against a queue-based stack model.
module tb_lifo_drain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int HSZ   = 4096;

  logic             clk;
  logic             rst;
  logic             lifo_rst;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             cmd_valid;
  logic [CNT_W-1:0] cmd_count;
  logic             m_ready;
  logic             cmd_ready;
  logic             lifo_pop;
  logic             lifo_empty;
  logic             lifo_full;
  logic [WIDTH-1:0] lifo_dout;
  logic             busy;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             done;
  logic [CNT_W-1:0] done_count;

  int n_checks = 0;
  int n_errs   = 0;

  logic [WIDTH-1:0] model[$];

  lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lifo (
    .clk(clk), .rst(lifo_rst), .i_push(push), .i_push_data(push_data),
    .i_pop(lifo_pop), .o_dout(lifo_dout), .o_empty(lifo_empty), .o_full(lifo_full)
  );

  lifo_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .lifo_pop(lifo_pop), .lifo_empty(lifo_empty),
    .lifo_dout(lifo_dout), .busy(busy), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .done(done), .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: records stream/pop/done events with cycle stamps.
  int               cyc = 0;
  int               acc_cyc = 0;
  int               pop_total = 0;
  int               vr_total = 0;
  int               hs_total = 0;
  int               done_total = 0;
  int               bad_pop = 0;
  int               bad_last = 0;
  int               unstable = 0;
  int               done_cnt_seen = 0;
  int               pop_cyc [HSZ];
  int               vrise_cyc [HSZ];
  int               hs_cyc [HSZ];
  logic [WIDTH-1:0] hs_data [HSZ];
  logic             hs_last [HSZ];
  logic             prev_valid = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_cyc <= cyc;
      if (lifo_pop) begin
        pop_cyc[pop_total % HSZ] <= cyc;
        pop_total <= pop_total + 1;
        if (m_valid) bad_pop <= bad_pop + 1;
      end
      if (m_valid && !prev_valid) begin
        vrise_cyc[vr_total % HSZ] <= cyc;
        vr_total <= vr_total + 1;
      end
      if (m_valid && m_ready) begin
        hs_data[hs_total % HSZ] <= m_data;
        hs_last[hs_total % HSZ] <= m_last;
        hs_cyc[hs_total % HSZ]  <= cyc;
        hs_total <= hs_total + 1;
      end
      if (done) begin
        done_total    <= done_total + 1;
        done_cnt_seen <= int'(done_count);
      end
      if (m_last && !m_valid) bad_last <= bad_last + 1;
      if (prev_stall && (!m_valid || m_data != prev_data || m_last != prev_last))
        unstable <= unstable + 1;
    end
    prev_valid <= m_valid && !rst;
    prev_stall <= m_valid && !m_ready && !rst;
    prev_data  <= m_data;
    prev_last  <= m_last;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] v);
    push = 1'b1;
    push_data = v;
    step();
    push = 1'b0;
    model.push_back(v);
  endtask

  // Reference: a drain takes min(count, size) newest entries, or all when count is 0.
  task automatic model_drain(input int cnt, output logic [WIDTH-1:0] exp[$]);
    int n;
    exp = {};
    n = (cnt == 0 || cnt > model.size()) ? model.size() : cnt;
    for (int i = 0; i < n; i++) exp.push_back(model.pop_back());
  endtask

  task automatic run_drain(input int cnt, input int stall_at, input int stall_len,
                           input bit rnd_ready, output bit tmo);
    int base_done;
    int base_hs;
    int stalled;
    base_done = done_total;
    base_hs   = hs_total;
    stalled   = 0;
    cmd_valid = 1'b1;
    cmd_count = CNT_W'(cnt);
    m_ready   = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 400 && done_total == base_done; k++) begin
      if (rnd_ready) m_ready = 1'($urandom % 2);
      else if (m_valid && (hs_total - base_hs) == stall_at && stalled < stall_len) begin
        m_ready = 1'b0;
        stalled++;
      end else m_ready = 1'b1;
      step();
    end
    tmo = (done_total == base_done);
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lifo_rst = 1'b1; push = 1'b0; push_data = '0;
    cmd_valid = 1'b0; cmd_count = '0; m_ready = 1'b1;
    step(); step();
    rst = 1'b0; lifo_rst = 1'b0;
    n_checks++; if ({m_valid, m_last, done, busy, lifo_pop} !== 5'b0) begin
      n_errs++; $display("FAIL reset_ctrl: got %b want 00000", {m_valid, m_last, done, busy, lifo_pop});
    end
    n_checks++; if (cmd_ready !== 1'b1) begin
      n_errs++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    n_checks++; if (m_data !== '0 || done_count !== '0) begin
      n_errs++; $display("FAIL reset_data: got m_data=%h done_count=%0d want 0/0", m_data, done_count);
    end
  endtask

  task automatic test_full_drain();
    logic [WIDTH-1:0] exp[$];
    int hs0, p0, v0;
    bit tmo;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    hs0 = hs_total; p0 = pop_total; v0 = vr_total;
    run_drain(0, -1, 0, 1'b0, tmo);
    model_drain(0, exp);
    n_checks++; if (tmo) begin n_errs++; $display("FAIL full_timeout: got no done want done"); end
    n_checks++; if (done_cnt_seen != 3) begin
      n_errs++; $display("FAIL full_done_count: got %0d want 3", done_cnt_seen);
    end
    n_checks++; if (hs_total - hs0 != exp.size()) begin
      n_errs++; $display("FAIL full_words: got %0d want %0d", hs_total - hs0, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (hs_data[hs0 + i] !== exp[i] || hs_last[hs0 + i] !== (i == exp.size() - 1)) begin
        n_errs++; $display("FAIL full_word%0d: got %h/%b want %h/%b", i, hs_data[hs0 + i],
                           hs_last[hs0 + i], exp[i], i == exp.size() - 1);
      end
    end
    n_checks++; if (lifo_empty !== 1'b1) begin
      n_errs++; $display("FAIL full_empty_after: got %b want 1", lifo_empty);
    end
    n_checks++; if (pop_cyc[p0] - acc_cyc != 1 || vrise_cyc[v0] - acc_cyc != 3) begin
      n_errs++; $display("FAIL full_latency: got pop+%0d valid+%0d want +1/+3",
                         pop_cyc[p0] - acc_cyc, vrise_cyc[v0] - acc_cyc);
    end
    n_checks++; if (pop_cyc[p0 + 1] - hs_cyc[hs0] != 1 || hs_cyc[hs0 + 1] - hs_cyc[hs0] != 3) begin
      n_errs++; $display("FAIL full_throughput: got pop gap %0d hs gap %0d want 1/3",
                         pop_cyc[p0 + 1] - hs_cyc[hs0], hs_cyc[hs0 + 1] - hs_cyc[hs0]);
    end
  endtask

  task automatic test_empty_drain();
    int p0, v0;
    p0 = pop_total; v0 = vr_total;
    cmd_valid = 1'b1; cmd_count = 4'd4;
    step();
    cmd_valid = 1'b0;
    n_checks++; if (lifo_pop !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_errs++; $display("FAIL empty_pop_cycle: got pop=%b busy=%b rdy=%b want 0/1/0", lifo_pop, busy, cmd_ready);
    end
    step();
    n_checks++; if (done !== 1'b1 || done_count !== 4'd0) begin
      n_errs++; $display("FAIL empty_done: got done=%b count=%0d want 1/0", done, done_count);
    end
    step();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_errs++; $display("FAIL empty_idle: got done=%b busy=%b want 0/0", done, busy);
    end
    step();
    n_checks++; if (pop_total != p0 || vr_total != v0) begin
      n_errs++; $display("FAIL empty_traffic: got pops=%0d valids=%0d want 0/0", pop_total - p0, vr_total - v0);
    end
  endtask

  task automatic test_partial_drain();
    logic [WIDTH-1:0] exp[$];
    int hs0;
    bit tmo;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    hs0 = hs_total;
    run_drain(2, -1, 0, 1'b0, tmo);
    model_drain(2, exp);
    n_checks++; if (tmo || done_cnt_seen != 2) begin
      n_errs++; $display("FAIL partial_done: got tmo=%b count=%0d want 0/2", tmo, done_cnt_seen);
    end
    n_checks++; if (hs_total - hs0 != 2) begin
      n_errs++; $display("FAIL partial_words: got %0d want 2", hs_total - hs0);
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (hs_data[hs0 + i] !== exp[i] || hs_last[hs0 + i] !== (i == 1)) begin
        n_errs++; $display("FAIL partial_word%0d: got %h/%b want %h/%b", i, hs_data[hs0 + i],
                           hs_last[hs0 + i], exp[i], i == 1);
      end
    end
    n_checks++; if (lifo_empty !== 1'b0 || model.size() != 1) begin
      n_errs++; $display("FAIL partial_left: got empty=%b want 0", lifo_empty);
    end
  endtask

  task automatic test_overcount();
    logic [WIDTH-1:0] exp[$];
    int hs0;
    bit tmo;
    push_word(8'h5A);
    hs0 = hs_total;
    run_drain(5, -1, 0, 1'b0, tmo);
    model_drain(5, exp);
    n_checks++; if (tmo || done_cnt_seen != 2) begin
      n_errs++; $display("FAIL over_done: got tmo=%b count=%0d want 0/2", tmo, done_cnt_seen);
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (hs_data[hs0 + i] !== exp[i] || hs_last[hs0 + i] !== (i == 1)) begin
        n_errs++; $display("FAIL over_word%0d: got %h/%b want %h/%b", i, hs_data[hs0 + i],
                           hs_last[hs0 + i], exp[i], i == 1);
      end
    end
    n_checks++; if (lifo_empty !== 1'b1) begin
      n_errs++; $display("FAIL over_empty: got %b want 1", lifo_empty);
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] exp[$];
    int hs0, p0, u0, b0;
    bit tmo;
    for (int i = 1; i <= DEPTH; i++) push_word(WIDTH'(i));
    hs0 = hs_total; p0 = pop_total; u0 = unstable; b0 = bad_pop;
    run_drain(0, 1, 5, 1'b0, tmo);
    model_drain(0, exp);
    n_checks++; if (tmo || done_cnt_seen != 8) begin
      n_errs++; $display("FAIL stall_done: got tmo=%b count=%0d want 0/8", tmo, done_cnt_seen);
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (hs_data[hs0 + i] !== exp[i] || hs_last[hs0 + i] !== (i == 7)) begin
        n_errs++; $display("FAIL stall_word%0d: got %h/%b want %h/%b", i, hs_data[hs0 + i],
                           hs_last[hs0 + i], exp[i], i == 7);
      end
    end
    n_checks++; if (hs_data[hs0 + 1] !== 8'h07 || hs_cyc[hs0 + 1] - hs_cyc[hs0] != 8) begin
      n_errs++; $display("FAIL stall_hold: got %h gap %0d want 07 gap 8", hs_data[hs0 + 1],
                         hs_cyc[hs0 + 1] - hs_cyc[hs0]);
    end
    n_checks++; if (unstable != u0 || bad_pop != b0 || pop_total - p0 != 8) begin
      n_errs++; $display("FAIL stall_protocol: got unstable=%0d extra_pop=%0d pops=%0d want 0/0/8",
                         unstable - u0, bad_pop - b0, pop_total - p0);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [WIDTH-1:0] exp[$];
    int hs0, k;
    bit tmo;
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    cmd_valid = 1'b1; cmd_count = '0; m_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (k = 0; k < 20 && !m_valid; k++) step();
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'hA3) begin
      n_errs++; $display("FAIL rmid_send: got valid=%b data=%h want 1/a3", m_valid, m_data);
    end
    rst = 1'b1;
    step();
    n_checks++; if ({m_valid, busy, cmd_ready, done} !== 4'b0010 || done_count !== '0) begin
      n_errs++; $display("FAIL rmid_abort: got v/b/r/d=%b cnt=%0d want 0010/0",
                         {m_valid, busy, cmd_ready, done}, done_count);
    end
    rst = 1'b0; m_ready = 1'b1;
    void'(model.pop_back());
    hs0 = hs_total;
    run_drain(0, -1, 0, 1'b0, tmo);
    model_drain(0, exp);
    n_checks++; if (tmo || done_cnt_seen != 2) begin
      n_errs++; $display("FAIL rmid_redrain: got tmo=%b count=%0d want 0/2", tmo, done_cnt_seen);
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (hs_data[hs0 + i] !== exp[i]) begin
        n_errs++; $display("FAIL rmid_word%0d: got %h want %h", i, hs_data[hs0 + i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp[$];
    int hs0, npush, cnt;
    int u0, b0, l0;
    bit tmo;
    u0 = unstable; b0 = bad_pop; l0 = bad_last;
    for (int it = 0; it < 30; it++) begin
      npush = $urandom_range(0, DEPTH - model.size());
      for (int j = 0; j < npush; j++) push_word(WIDTH'($urandom));
      cnt = $urandom_range(0, 10);
      hs0 = hs_total;
      run_drain(cnt, -1, 0, 1'b1, tmo);
      model_drain(cnt, exp);
      n_checks++; if (tmo || done_cnt_seen != exp.size() || hs_total - hs0 != exp.size()) begin
        n_errs++; $display("FAIL rnd%0d_count: got tmo=%b done=%0d words=%0d want %0d", it, tmo,
                           done_cnt_seen, hs_total - hs0, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++; if (hs_data[hs0 + i] !== exp[i] || hs_last[hs0 + i] !== (i == exp.size() - 1)) begin
          n_errs++; $display("FAIL rnd%0d_word%0d: got %h/%b want %h/%b", it, i, hs_data[hs0 + i],
                             hs_last[hs0 + i], exp[i], i == exp.size() - 1);
        end
      end
      n_checks++; if (lifo_empty !== (model.size() == 0)) begin
        n_errs++; $display("FAIL rnd%0d_empty: got %b want %b", it, lifo_empty, model.size() == 0);
      end
    end
    n_checks++; if (unstable != u0 || bad_pop != b0 || bad_last != l0) begin
      n_errs++; $display("FAIL rnd_protocol: got unstable=%0d extra_pop=%0d stray_last=%0d want 0",
                         unstable - u0, bad_pop - b0, bad_last - l0);
    end
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_empty_drain();
    test_partial_drain();
    test_overcount();
    test_stall();
    test_reset_mid_send();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
